// File: rtl/apb4_master_bridge.sv
`default_nettype none
// apb4_master_bridge: turns single-cycle requester transfers into APB4 SETUP/ACCESS phases.
// Rev 1.0 - PREADY-wait timeout aborts a hung access with SSLVERR/STIMEOUT.
module apb4_master_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_STRB_WIDTH = APB_DATA_WIDTH / 8,
  parameter int APB_PROT_WIDTH = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      transfer,
  input  logic                      SWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] SADDR,
  input  logic [APB_DATA_WIDTH-1:0] SWDATA,
  input  logic [APB_STRB_WIDTH-1:0] SSTRB,
  input  logic [APB_PROT_WIDTH-1:0] SPROT,
  output logic                      SREADY,
  output logic                      SDONE,
  output logic [APB_DATA_WIDTH-1:0] SRDATA,
  output logic                      SSLVERR,
  output logic                      STIMEOUT,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic [APB_STRB_WIDTH-1:0] PSTRB,
  output logic [APB_PROT_WIDTH-1:0] PPROT,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  output logic [1:0]                cs
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [APB_STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [APB_PROT_WIDTH-1:0] pprot_q, pprot_d;
  logic [APB_DATA_WIDTH-1:0] srdata_q, srdata_d;
  logic                      sdone_q, sdone_d;
  logic                      sslverr_q, sslverr_d;
  logic                      stimeout_q, stimeout_d;
  logic                      accept;
  logic                      timeout_hit;

  assign SREADY      = (state_q == ST_IDLE) | ((state_q == ST_ACCESS) & PREADY);
  assign accept      = transfer & SREADY;
  // A ready slave on the last allowed cycle still completes normally.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state_q == ST_ACCESS) && !PREADY && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    pprot_d    = pprot_q;
    srdata_d   = srdata_q;
    sdone_d    = 1'b0;
    sslverr_d  = 1'b0;
    stimeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (transfer) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          sdone_d   = 1'b1;
          sslverr_d = PSLVERR;
          if (!pwrite_q) srdata_d = PRDATA;
          cnt_d     = '0;
          state_d   = transfer ? ST_SETUP : ST_IDLE;
        end else if (timeout_hit) begin
          sdone_d    = 1'b1;
          sslverr_d  = 1'b1;
          stimeout_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Reads drive PSTRB low.
    if (accept) begin
      pwrite_d = SWRITE;
      paddr_d  = SADDR;
      pwdata_d = SWDATA;
      pstrb_d  = SWRITE ? SSTRB : '0;
      pprot_d  = SPROT;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      pprot_q    <= '0;
      srdata_q   <= '0;
      sdone_q    <= 1'b0;
      sslverr_q  <= 1'b0;
      stimeout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      pprot_q    <= pprot_d;
      srdata_q   <= srdata_d;
      sdone_q    <= sdone_d;
      sslverr_q  <= sslverr_d;
      stimeout_q <= stimeout_d;
    end
  end

  assign PSEL     = (state_q != ST_IDLE);
  assign PENABLE  = (state_q == ST_ACCESS);
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PSTRB    = pstrb_q;
  assign PPROT    = pprot_q;
  assign SRDATA   = srdata_q;
  assign SDONE    = sdone_q;
  assign SSLVERR  = sslverr_q;
  assign STIMEOUT = stimeout_q;
  assign cs       = state_q;

endmodule
`default_nettype wire
